// File: rtl/ctrl_pkg.sv
// Shared constants for the bus computer control unit:
// control-bit positions, opcodes and fetch words.
package ctrl_pkg;

  localparam int CTRL_W = 16;

  localparam int B_HLT = 15;
  localparam int B_MI  = 14;
  localparam int B_RI  = 13;
  localparam int B_RO  = 12;
  localparam int B_IO  = 11;
  localparam int B_II  = 10;
  localparam int B_AI  = 9;
  localparam int B_AO  = 8;
  localparam int B_EO  = 7;
  localparam int B_SU  = 6;
  localparam int B_BI  = 5;
  localparam int B_OI  = 4;
  localparam int B_CE  = 3;
  localparam int B_CO  = 2;
  localparam int B_J   = 1;
  localparam int B_FI  = 0;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  function automatic logic [CTRL_W-1:0] cbit(input int idx);
    logic [CTRL_W-1:0] w;
    w = '0;
    w[idx] = 1'b1;
    return w;
  endfunction

  localparam logic [CTRL_W-1:0] FETCH_T0 = cbit(B_CO) | cbit(B_MI);
  localparam logic [CTRL_W-1:0] FETCH_T1 =
    cbit(B_RO) | cbit(B_II) | cbit(B_CE);

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode table: (opcode, step, flags) -> control word.
// Steps with no work return zero, which the sequencer uses as end-of-instruction.
module microcode_rom
  import ctrl_pkg::*;
#(
  parameter int STEP_W = 3
) (
  input  logic [3:0]        opcode,
  input  logic [STEP_W-1:0] step,
  input  logic              carry_flag,
  input  logic              zero_flag,
  output logic [CTRL_W-1:0] word
);

  // Decode the control word for one microstep
  always_comb begin
    word = '0;
    case (32'(step))
      0: word = FETCH_T0;
      1: word = FETCH_T1;
      2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA:
            word = cbit(B_IO) | cbit(B_MI);
          OP_LDI: word = cbit(B_IO) | cbit(B_AI);
          OP_JMP: word = cbit(B_IO) | cbit(B_J);
          OP_JC:
            if (carry_flag) word = cbit(B_IO) | cbit(B_J);
          OP_JZ:
            if (zero_flag) word = cbit(B_IO) | cbit(B_J);
          OP_OUT: word = cbit(B_AO) | cbit(B_OI);
          OP_HLT: word = cbit(B_HLT);
          default: word = '0;
        endcase
      end
      3: begin
        case (opcode)
          OP_LDA: word = cbit(B_RO) | cbit(B_AI);
          OP_ADD, OP_SUB:
            word = cbit(B_RO) | cbit(B_BI);
          OP_STA: word = cbit(B_AO) | cbit(B_RI);
          default: word = '0;
        endcase
      end
      4: begin
        case (opcode)
          OP_ADD:
            word = cbit(B_EO) | cbit(B_AI) | cbit(B_FI);
          OP_SUB:
            word = cbit(B_EO) | cbit(B_AI)
                 | cbit(B_SU) | cbit(B_FI);
          default: word = '0;
        endcase
      end
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Microstep sequencer: steps fetch/execute, ends instructions early on an
// empty next word, and freezes on HLT until reset.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int MAX_STEPS = 5,
  parameter int STEP_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        opcode,
  input  logic              carry_flag,
  input  logic              zero_flag,
  output logic [15:0]       ctrl,
  output logic [STEP_W-1:0] step,
  output logic              halted
);

  logic [CTRL_W-1:0] cur_word;
  logic [CTRL_W-1:0] nxt_word;
  logic [STEP_W-1:0] step_inc;
  logic              last_step;
  logic              early_end;

  assign step_inc = step + STEP_W'(1);

  microcode_rom #(.STEP_W(STEP_W)) u_cur (
    .opcode     (opcode),
    .step       (step),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .word       (cur_word)
  );

  // Lookahead: an empty next word lets the instruction end now
  microcode_rom #(.STEP_W(STEP_W)) u_nxt (
    .opcode     (opcode),
    .step       (step_inc),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .word       (nxt_word)
  );

  assign last_step = (step == STEP_W'(MAX_STEPS - 1));
  assign early_end = (step >= STEP_W'(2)) && (nxt_word == '0);

  // Advance the microstep, latch halt, hold everything once halted
  always_ff @(posedge clk) begin
    if (rst) begin
      step   <= '0;
      halted <= 1'b0;
    end else if (!halted) begin
      if (cur_word[B_HLT]) begin
        halted <= 1'b1;
      end else if (last_step || early_end) begin
        step <= '0;
      end else begin
        step <= step_inc;
      end
    end
  end

  // Once halted only the HLT strobe stays asserted
  assign ctrl = halted ? cbit(B_HLT) : cur_word;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: fetch/execute sequences,
// early end, halt freeze, mid-instruction reset and an opcode sweep.
module tb_control_sequencer;

  logic        clk;
  logic        rst;
  logic [3:0]  opcode;
  logic        carry_flag;
  logic        zero_flag;
  logic [15:0] ctrl;
  logic [2:0]  step;
  logic        halted;

  int n_checks;
  int n_errors;

  control_sequencer #(.MAX_STEPS(5), .STEP_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .ctrl       (ctrl),
    .step       (step),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int drivers(input logic [15:0] w);
    return int'(w[12]) + int'(w[11]) + int'(w[8])
         + int'(w[7]) + int'(w[2]);
  endfunction

  // Hand-written microcode table for T2..T4
  function automatic logic [15:0] exp_exec(input logic [3:0] op,
                                           input logic c,
                                           input logic z,
                                           input int t);
    logic [15:0] w;
    w = 16'h0000;
    case (op)
      4'h1: w = (t == 2) ? 16'h4800 : (t == 3) ? 16'h1200 : 16'h0;
      4'h2: w = (t == 2) ? 16'h4800 : (t == 3) ? 16'h1020 : 16'h0281;
      4'h3: w = (t == 2) ? 16'h4800 : (t == 3) ? 16'h1020 : 16'h02C1;
      4'h4: w = (t == 2) ? 16'h4800 : (t == 3) ? 16'h2100 : 16'h0;
      4'h5: w = (t == 2) ? 16'h0A00 : 16'h0;
      4'h6: w = (t == 2) ? 16'h0802 : 16'h0;
      4'h7: w = (t == 2 && c) ? 16'h0802 : 16'h0;
      4'h8: w = (t == 2 && z) ? 16'h0802 : 16'h0;
      4'hE: w = (t == 2) ? 16'h0110 : 16'h0;
      default: w = 16'h0;
    endcase
    return w;
  endfunction

  function automatic int exp_len(input logic [3:0] op);
    case (op)
      4'h1, 4'h4: return 4;
      4'h2, 4'h3: return 5;
      default:    return 3;
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic run_instr(input logic [3:0] op,
                           input logic c,
                           input logic z);
    logic [15:0] w;
    int len;
    opcode = op;
    carry_flag = c;
    zero_flag = z;
    #1;
    len = exp_len(op);
    for (int t = 0; t < len; t++) begin
      w = (t == 0) ? 16'h4004 : (t == 1) ? 16'h1408
                              : exp_exec(op, c, z, t);
      check($sformatf("op%0h_c%0d_t%0d_ctrl", op, c, t),
            32'(ctrl), 32'(w));
      check($sformatf("op%0h_c%0d_t%0d_step", op, c, t),
            32'(step), 32'(t));
      if (ctrl != 16'h0)
        check($sformatf("op%0h_t%0d_one_driver", op, t),
              32'(drivers(ctrl) <= 1), 32'd1);
      tick();
    end
    check($sformatf("op%0h_c%0d_end_step", op, c), 32'(step), 32'd0);
    check($sformatf("op%0h_c%0d_end_ctrl", op, c), 32'(ctrl), 32'h4004);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    opcode = 4'h0;
    carry_flag = 1'b0;
    zero_flag = 1'b0;
    #2;
    do_reset();
    check("rst_step", 32'(step), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_ctrl", 32'(ctrl), 32'h4004);

    // LDA, ADD, JC not taken / taken
    run_instr(4'h1, 1'b0, 1'b0);
    run_instr(4'h2, 1'b0, 1'b0);
    run_instr(4'h7, 1'b0, 1'b0);
    run_instr(4'h7, 1'b1, 1'b0);

    // HLT freezes step and output until reset
    opcode = 4'hF;
    #1;
    tick();
    tick();
    check("hlt_t2_ctrl", 32'(ctrl), 32'h8000);
    check("hlt_t2_step", 32'(step), 32'd2);
    check("hlt_t2_halted", 32'(halted), 32'd0);
    tick();
    check("hlt_halted", 32'(halted), 32'd1);
    for (int i = 0; i < 20; i++) begin
      opcode = 4'($urandom_range(0, 15));
      carry_flag = 1'($urandom_range(0, 1));
      zero_flag = 1'($urandom_range(0, 1));
      #1;
      check($sformatf("hold%0d_step", i), 32'(step), 32'd2);
      check($sformatf("hold%0d_ctrl", i), 32'(ctrl), 32'h8000);
      check($sformatf("hold%0d_halted", i), 32'(halted), 32'd1);
      tick();
    end
    do_reset();
    check("unhalt_step", 32'(step), 32'd0);
    check("unhalt_halted", 32'(halted), 32'd0);
    check("unhalt_ctrl", 32'(ctrl), 32'h4004);

    // Reset in T3 of SUB abandons the instruction
    opcode = 4'h3;
    carry_flag = 1'b0;
    zero_flag = 1'b0;
    #1;
    tick();
    tick();
    tick();
    check("sub_t3_step", 32'(step), 32'd3);
    check("sub_t3_ctrl", 32'(ctrl), 32'h1020);
    do_reset();
    check("sub_rst_step", 32'(step), 32'd0);
    check("sub_rst_ctrl", 32'(ctrl), 32'h4004);
    tick();
    check("sub_rst_t1_ctrl", 32'(ctrl), 32'h1408);
    do_reset();

    // Sweep every non-halting opcode with both flag polarities
    for (int op = 0; op < 15; op++) begin
      for (int f = 0; f < 2; f++) begin
        run_instr(4'(op), 1'(f), 1'(1 - f));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
